postprocessor: RTL and testbench

Requantizing output stage between the convolution accumulator array and `maxpool`. It takes `Tout` 32-bit signed partial sums per cycle, adds per-channel bias, scales and shifts them, applies ReLU and saturates each lane to 8 bits. It packs the lanes into one feature-map word and tags it with the output pixel's row, column and channel-tile index. Its `pp_*` outputs drive `maxpool` directly.

---
 rtl/postprocessor_pkg.sv | 20 ++
 rtl/pp_lane.sv | 95 +++++++++
 rtl/postprocessor.sv | 177 +++++++++++++++++
 tb/tb_postprocessor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/postprocessor_pkg.sv
// Shared widths and types for the requantizing postprocessor.
// Bundle: postprocessor_pkg, pp_lane, postprocessor (option: PP_ROUND_EN).
package postprocessor_pkg;

  localparam int W_DATA       = 8;
  localparam int FM_BUFFER_DW = 32;
  localparam int PP_PSUM_DW   = 32;
  localparam int PP_BIAS_DW   = 16;
  localparam int PP_SCALE_DW  = 16;
  localparam int PP_SHIFT_W   = 5;
  localparam int PP_W_SIZE    = 10;
  localparam int PP_W_CHANNEL = 8;
  localparam int PP_TOUT      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pp_state_t;

endpackage

// File: rtl/pp_lane.sv
// One lane: bias add (sat), scale multiply, shift and clamp to 8 bits.
// PP_ROUND_EN adds a round-half-up constant ahead of the shift.
module pp_lane
  import postprocessor_pkg::*;
#(
  parameter int PSUM_DW  = PP_PSUM_DW,
  parameter int BIAS_DW  = PP_BIAS_DW,
  parameter int SCALE_DW = PP_SCALE_DW,
  parameter int OUT_DW   = W_DATA
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [2:0]            en,
  input  logic [PSUM_DW-1:0]    acc,
  input  logic [BIAS_DW-1:0]    bias,
  input  logic [SCALE_DW-1:0]   scale,
  input  logic [PP_SHIFT_W-1:0] shift,
  output logic [OUT_DW-1:0]     dout
);

  localparam int S2_W = PSUM_DW + SCALE_DW + 1;
  localparam int S3_W = S2_W + 1;

  logic signed [PSUM_DW:0]   sum;
  logic signed [PSUM_DW-1:0] s1_d;
  logic signed [PSUM_DW-1:0] s1_q;
  logic signed [S2_W-1:0]    s2_d;
  logic signed [S2_W-1:0]    s2_q;
  logic signed [S3_W-1:0]    s3_add;
  logic signed [S3_W-1:0]    s3_sh;
  logic [OUT_DW-1:0]         out_d;

  // Stage 1: widen by one bit, add, saturate back to PSUM_DW
  always_comb begin
    sum = $signed({acc[PSUM_DW-1], acc})
        + $signed({{(PSUM_DW+1-BIAS_DW){bias[BIAS_DW-1]}}, bias});
    s1_d = sum[PSUM_DW-1:0];
    if (sum[PSUM_DW] != sum[PSUM_DW-1]) begin
      s1_d = sum[PSUM_DW] ? {1'b1, {(PSUM_DW-1){1'b0}}}
                          : {1'b0, {(PSUM_DW-1){1'b1}}};
    end
  end

  // Stage 2: signed times zero-extended scale
  always_comb begin
    s2_d = S2_W'(s1_q) * S2_W'($signed({1'b0, scale}));
  end

`ifdef PP_ROUND_EN
  logic signed [S3_W-1:0] rnd;

  // Half an LSB of the shifted result, none when shift is zero
  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = S3_W'(1) <<< (shift - 5'd1);
    end
  end

  // Stage 3 pre-shift with rounding constant
  always_comb begin
    s3_add = S3_W'(s2_q) + rnd;
  end
`else
  // Stage 3 pre-shift, plain truncation
  always_comb begin
    s3_add = S3_W'(s2_q);
  end
`endif

  // Stage 3: arithmetic shift then clamp to [0, 2^OUT_DW-1]
  always_comb begin
    s3_sh = s3_add >>> shift;
    out_d = s3_sh[OUT_DW-1:0];
    if (s3_sh[S3_W-1]) begin
      out_d = '0;
    end else if (|s3_sh[S3_W-2:OUT_DW]) begin
      out_d = '1;
    end
  end

  // Pipeline registers, each loaded only with a valid word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= '0;
      s2_q <= '0;
      dout <= '0;
    end else begin
      if (en[0]) s1_q <= s1_d;
      if (en[1]) s2_q <= s2_d;
      if (en[2]) dout <= out_d;
    end
  end

endmodule

// File: rtl/postprocessor.sv
// Requant output stage: counters, tile bias, tag pipeline, Tout lanes.
// Build option PP_ROUND_EN selects round-half-up in every lane.
module postprocessor
  import postprocessor_pkg::*;
#(
  parameter int W_SIZE    = PP_W_SIZE,
  parameter int W_CHANNEL = PP_W_CHANNEL,
  parameter int Tout      = PP_TOUT,
  parameter int PSUM_DW   = PP_PSUM_DW,
  parameter int BIAS_DW   = PP_BIAS_DW,
  parameter int SCALE_DW  = PP_SCALE_DW,
  parameter int OUT_DW    = W_DATA,
  parameter int OFM_DW    = FM_BUFFER_DW
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CHANNEL-1:0]    q_channel_out,
  input  logic [SCALE_DW-1:0]     q_scale,
  input  logic [PP_SHIFT_W-1:0]   q_shift,
  input  logic [Tout*BIAS_DW-1:0] i_bias,
  input  logic                    acc_vld,
  input  logic [Tout*PSUM_DW-1:0] acc_data,
  output logic                    pp_data_vld,
  output logic [OFM_DW-1:0]       pp_data,
  output logic [W_SIZE-1:0]       pp_row,
  output logic [W_SIZE-1:0]       pp_col,
  output logic [W_CHANNEL-1:0]    pp_chn_out,
  output logic                    o_busy,
  output logic                    o_done
);

  pp_state_t state, state_nxt;

  logic [W_SIZE-1:0]       col, row;
  logic [W_CHANNEL-1:0]    chn;
  logic [W_SIZE-1:0]       col_e, row_e;
  logic [W_CHANNEL-1:0]    chn_e;
  logic                    take, col_end, row_end, chn_end;
  logic                    is_last, first_px;
  logic [Tout*BIAS_DW-1:0] bias_q, bias_use;

  logic                    v1, v2;
  logic                    last1, last2;
  logic [W_SIZE-1:0]       row1, row2, col1, col2;
  logic [W_CHANNEL-1:0]    chn1, chn2;

  // A start in the same cycle makes the word pixel (0,0,0)
  always_comb begin
    take     = acc_vld & (i_start | (state == RUN));
    col_e    = i_start ? '0 : col;
    row_e    = i_start ? '0 : row;
    chn_e    = i_start ? '0 : chn;
    col_end  = col_e == (q_width - W_SIZE'(1));
    row_end  = row_e == (q_height - W_SIZE'(1));
    chn_end  = chn_e == (q_channel_out - W_CHANNEL'(1));
    is_last  = take & col_end & row_end & chn_end;
    first_px = take & (col_e == '0) & (row_e == '0);
    bias_use = first_px ? i_bias : bias_q;
  end

  // Next state: start enters RUN, the last word returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_start) state_nxt = RUN;
      RUN:  if (i_start) state_nxt = RUN;
    endcase
    if (is_last) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pixel counters: col fastest, then row, then channel tile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
      chn <= '0;
    end else if (take) begin
      if (!col_end) begin
        col <= col_e + W_SIZE'(1);
        row <= row_e;
        chn <= chn_e;
      end else if (!row_end) begin
        col <= '0;
        row <= row_e + W_SIZE'(1);
        chn <= chn_e;
      end else begin
        col <= '0;
        row <= '0;
        chn <= chn_end ? '0 : chn_e + W_CHANNEL'(1);
      end
    end else if (i_start) begin
      col <= '0;
      row <= '0;
      chn <= '0;
    end
  end

  // Tile bias, captured on the first pixel of each tile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         bias_q <= '0;
    else if (first_px) bias_q <= i_bias;
  end

  // Tag pipeline alongside lane stages 1 and 2
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0; last1 <= 1'b0;
      row1 <= '0; col1 <= '0; chn1 <= '0;
      v2 <= 1'b0; last2 <= 1'b0;
      row2 <= '0; col2 <= '0; chn2 <= '0;
    end else begin
      v1 <= take;
      v2 <= v1;
      if (take) begin
        last1 <= is_last;
        row1  <= row_e;
        col1  <= col_e;
        chn1  <= chn_e;
      end
      if (v1) begin
        last2 <= last1;
        row2  <= row1;
        col2  <= col1;
        chn2  <= chn1;
      end
    end
  end

  // Output tags hold their last values between valid words
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pp_data_vld <= 1'b0;
      o_done      <= 1'b0;
      pp_row      <= '0;
      pp_col      <= '0;
      pp_chn_out  <= '0;
    end else begin
      pp_data_vld <= v2;
      o_done      <= v2 & last2;
      if (v2) begin
        pp_row     <= row2;
        pp_col     <= col2;
        pp_chn_out <= chn2;
      end
    end
  end

  assign o_busy = (state == RUN) | v1 | v2 | pp_data_vld;

  for (genvar k = 0; k < Tout; k++) begin : g_lane
    pp_lane #(
      .PSUM_DW  (PSUM_DW),
      .BIAS_DW  (BIAS_DW),
      .SCALE_DW (SCALE_DW),
      .OUT_DW   (OUT_DW)
    ) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .en    ({v2, v1, take}),
      .acc   (acc_data[k*PSUM_DW +: PSUM_DW]),
      .bias  (bias_use[k*BIAS_DW +: BIAS_DW]),
      .scale (q_scale),
      .shift (q_shift),
      .dout  (pp_data[k*OUT_DW +: OUT_DW])
    );
  end

endmodule

// File: tb/tb_postprocessor.sv
// Randomized bench for postprocessor against a queue-based reference.
// Honours PP_ROUND_EN the same way the design does.
module tb_postprocessor;
  import postprocessor_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_start;
  logic [9:0]    q_width, q_height;
  logic [7:0]    q_channel_out;
  logic [15:0]   q_scale;
  logic [4:0]    q_shift;
  logic [63:0]   i_bias;
  logic          acc_vld;
  logic [127:0]  acc_data;
  logic          pp_data_vld;
  logic [31:0]   pp_data;
  logic [9:0]    pp_row, pp_col;
  logic [7:0]    pp_chn_out;
  logic          o_busy, o_done;

  postprocessor dut (
    .clk(clk), .rstn(rstn), .i_start(i_start),
    .q_width(q_width), .q_height(q_height),
    .q_channel_out(q_channel_out),
    .q_scale(q_scale), .q_shift(q_shift),
    .i_bias(i_bias), .acc_vld(acc_vld),
    .acc_data(acc_data),
    .pp_data_vld(pp_data_vld), .pp_data(pp_data),
    .pp_row(pp_row), .pp_col(pp_col),
    .pp_chn_out(pp_chn_out),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    int          chn;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          vld_cnt = 0;
  int          done_cnt = 0;
  bit          m_active = 0;
  int          m_k = 0;
  logic [63:0] m_bias = '0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_lane(
    input int a, input shortint b,
    input int sc, input int sh);
    longint s1, s2, r, s3;
    s1 = longint'(a) + longint'(b);
    if (s1 > 64'sd2147483647) s1 = 64'sd2147483647;
    if (s1 < -64'sd2147483648) s1 = -64'sd2147483648;
    s2 = s1 * longint'(sc);
    r = 0;
`ifdef PP_ROUND_EN
    if (sh > 0) r = longint'(1) << (sh - 1);
`endif
    s3 = (s2 + r) >>> sh;
    if (s3 < 0) return 8'd0;
    if (s3 > 255) return 8'd255;
    return s3[7:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor against the expectation queue
  always @(negedge clk) begin
    if (rstn) begin
      if (o_done) done_cnt++;
      if (pp_data_vld) begin
        vld_cnt++;
        if (expq.size() == 0) begin
          chk("spurious_vld", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("data", pp_data, e.data);
          chk("row", pp_row, e.row);
          chk("col", pp_col, e.col);
          chk("chn", pp_chn_out, e.chn);
          chk("done", o_done, e.last);
          chk("latency", cyc, e.cyc);
        end
      end else begin
        chk("done_novld", o_done, 0);
      end
    end
  end

  // Drive one cycle and update the reference model
  task automatic step(input bit st, input bit v,
                      input logic [127:0] acc,
                      input logic [63:0] bias);
    int px, tile, pk;
    exp_t e;
    i_start  = st;
    acc_vld  = v;
    acc_data = acc;
    i_bias   = bias;
    if (st) begin
      m_active = 1;
      m_k = 0;
    end
    if (v && m_active) begin
      px   = int'(q_width) * int'(q_height);
      tile = px * int'(q_channel_out);
      pk   = m_k % px;
      if (pk == 0) m_bias = bias;
      e.col  = pk % int'(q_width);
      e.row  = pk / int'(q_width);
      e.chn  = m_k / px;
      e.last = (m_k == tile - 1);
      e.cyc  = cyc + 3;
      for (int k = 0; k < 4; k++) begin
        int a;
        shortint b;
        a = acc[k*32 +: 32];
        b = m_bias[k*16 +: 16];
        e.data[k*8 +: 8] = ref_lane(a, b,
          int'(q_scale), int'(q_shift));
      end
      expq.push_back(e);
      m_k++;
      if (e.last) m_active = 0;
    end
    @(posedge clk);
    #1;
    i_start = 0;
    acc_vld = 0;
  endtask

  function automatic logic [127:0] rnd_acc();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 3) == 0)
        r[k*32 +: 32] = $urandom;
      else
        r[k*32 +: 32] = $urandom_range(0, 4000) - 2000;
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd_bias();
    return {$urandom, $urandom};
  endfunction

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", expq.size(), 0);
  endtask

  task automatic set_q(input int w, input int h, input int c,
                       input int sc, input int sh);
    q_width       = 10'(w);
    q_height      = 10'(h);
    q_channel_out = 8'(c);
    q_scale       = 16'(sc);
    q_shift       = 5'(sh);
  endtask

  task automatic one_px(input string tag, input int a0,
                        input int b0, input int sc,
                        input int sh, input int exp0);
    logic [127:0] a;
    logic [63:0]  b;
    a = rnd_acc();
    b = rnd_bias();
    a[31:0] = a0;
    b[15:0] = 16'(b0);
    set_q(1, 1, 1, sc, sh);
    step(1, 1, a, b);
    drain();
    chk(tag, pp_data[7:0], exp0);
  endtask

  initial begin
    int d0, v0, n;
    rstn = 0;
    i_start = 0;
    acc_vld = 0;
    acc_data = '0;
    i_bias = '0;
    set_q(1, 1, 1, 1, 0);
    #12;
    chk("rst_vld", pp_data_vld, 0);
    chk("rst_data", pp_data, 0);
    chk("rst_tags", {pp_row, pp_col, pp_chn_out}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    @(posedge clk);
    #1;

    one_px("basic", 100, 28, 1024, 10, 128);
`ifdef PP_ROUND_EN
    one_px("round", 3, 0, 1, 1, 2);
`else
    one_px("round", 3, 0, 1, 1, 1);
`endif
    one_px("clamp_neg", -500, 0, 1, 0, 0);
    one_px("clamp_hi", 100000, 0, 1024, 10, 255);
    one_px("sat_s1", 32'h7FFFFFFF, 1, 1, 0, 255);

    // Ordering and per-tile bias, back to back
    set_q(2, 2, 2, 300, 6);
    d0 = done_cnt;
    step(1, 1, rnd_acc(), rnd_bias());
    for (int i = 0; i < 7; i++)
      step(0, 1, rnd_acc(), rnd_bias());
    drain();
    chk("order_done_cnt", done_cnt - d0, 1);
    chk("idle_after_done", o_busy, 0);

    // Words with no layer running are dropped
    v0 = vld_cnt;
    for (int i = 0; i < 4; i++)
      step(0, 1, rnd_acc(), rnd_bias());
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_vld", vld_cnt - v0, 0);

    // Random layers with gaps and a mid-layer restart
    for (int l = 0; l < 8; l++) begin
      set_q($urandom_range(1, 3), $urandom_range(1, 3),
            $urandom_range(1, 3), $urandom_range(0, 2048),
            $urandom_range(0, 12));
      step(1, $urandom_range(0, 1), rnd_acc(), rnd_bias());
      n = 0;
      while (m_active && n < 200) begin
        if (l == 3 && n == 2)
          step(1, 1, rnd_acc(), rnd_bias());
        else
          step(0, $urandom_range(0, 3) != 0,
               rnd_acc(), rnd_bias());
        n++;
      end
      chk("layer_bound", m_active, 0);
      drain();
    end

    // Reset in the middle of a layer
    set_q(2, 2, 1, 512, 8);
    d0 = done_cnt;
    step(1, 1, rnd_acc(), rnd_bias());
    step(0, 1, rnd_acc(), rnd_bias());
    step(0, 1, rnd_acc(), rnd_bias());
    rstn = 0;
    expq.delete();
    m_active = 0;
    m_k = 0;
    #1;
    chk("mrst_vld", pp_data_vld, 0);
    chk("mrst_data", pp_data, 0);
    chk("mrst_tags", {pp_row, pp_col, pp_chn_out}, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_done", o_done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1;
    chk("mrst_no_done", done_cnt - d0, 0);
    step(1, 1, rnd_acc(), rnd_bias());
    for (int i = 0; i < 3; i++)
      step(0, 1, rnd_acc(), rnd_bias());
    drain();
    chk("post_rst_done", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
